contador_bcd_param: RTL and testbench

Parameterised, fully synchronous multi-digit BCD counter with a programmable modulus per digit. It replaces the single-digit tens counter, which used JK flip-flops and a rippled derived clock. All digits share one clock. Advancing is gated by `enable`, and a registered wrap pulse (`carry`) cascades to the next counter stage as an enable, not as a clock. The standard instance uses DIGITS=2, MODULI=8'h6A to give a 00–59 seconds/minutes field for the clock datapath.

---
 rtl/contador_bcd_param_if.sv | 23 ++
 rtl/contador_bcd_param.sv | 90 +++++++++
 tb/tb_contador_bcd_param.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/contador_bcd_param_if.sv
// Bus bundle for contador_bcd_param: step/load controls in, BCD count and wrap flags out.
// DIGITS must match the counter instance it connects to.
interface contador_bcd_param_if #(
    parameter int DIGITS = 2
);
    logic                  i_enable;
    logic                  i_down;
    logic                  i_load;
    logic [4*DIGITS-1:0]   i_preset;
    logic [4*DIGITS-1:0]   o_q;
    logic                  o_carry;
    logic                  o_tc;

    modport master (
        output i_enable, i_down, i_load, i_preset,
        input  o_q, o_carry, o_tc
    );

    modport slave (
        input  i_enable, i_down, i_load, i_preset,
        output o_q, o_carry, o_tc
    );
endinterface

// File: rtl/contador_bcd_param.sv
// Synchronous multi-digit BCD counter, per-digit modulus; down counting only with CONTADOR_BCD_DOWN_EN.
// q/carry 1-cycle latency, tc combinational; no backpressure, a tick is consumed on every enabled edge.
module contador_bcd_param #(
    parameter int                  DIGITS = 2,
    parameter logic [4*DIGITS-1:0] MODULI = 8'h6A
) (
    input  logic                 i_clk,
    input  logic                 i_clear,
    contador_bcd_param_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]    r_q;
    logic            r_carry;

    logic [DIGITS:0] w_up_c;
    logic [W-1:0]    w_up_q;
    logic [W-1:0]    w_load_q;
    logic [W-1:0]    w_next_q;
    logic            w_wrap;
`ifdef CONTADOR_BCD_DOWN_EN
    logic [DIGITS:0] w_dn_c;
    logic [W-1:0]    w_dn_q;
    logic            w_down;
`endif

    // w_up_c[i] means every digit below i is at its max, so digit i steps this edge
    assign w_up_c[0] = 1'b1;
`ifdef CONTADOR_BCD_DOWN_EN
    assign w_dn_c[0] = 1'b1;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        localparam logic [3:0] MOD = MODULI[4*g +: 4];

        if (MOD < 4'd2 || MOD > 4'd10) begin : g_bad_modulus
            $error("contador_bcd_param: digit %0d modulus %0d outside 2..10", g, MOD);
        end

        logic [3:0] w_d;
        logic [3:0] w_p;
        logic       w_at_max;

        assign w_d      = r_q[4*g +: 4];
        assign w_p      = bus.i_preset[4*g +: 4];
        assign w_at_max = (w_d == MOD - 4'd1);

        assign w_up_c[g+1]       = w_up_c[g] && w_at_max;
        assign w_up_q[4*g +: 4]  = !w_up_c[g] ? w_d : (w_at_max ? 4'd0 : w_d + 4'd1);
        assign w_load_q[4*g +: 4] = (w_p < MOD) ? w_p : 4'd0;

`ifdef CONTADOR_BCD_DOWN_EN
        logic w_at_zero;
        assign w_at_zero         = (w_d == 4'd0);
        assign w_dn_c[g+1]       = w_dn_c[g] && w_at_zero;
        assign w_dn_q[4*g +: 4]  = !w_dn_c[g] ? w_d : (w_at_zero ? MOD - 4'd1 : w_d - 4'd1);
`endif
    end

`ifdef CONTADOR_BCD_DOWN_EN
    assign w_down   = bus.i_down;
    assign w_next_q = w_down ? w_dn_q : w_up_q;
    assign w_wrap   = w_down ? w_dn_c[DIGITS] : w_up_c[DIGITS];
`else
    // Direction input is kept on the interface but has no effect in an up-only build
    logic w_unused_down;
    assign w_unused_down = bus.i_down;
    assign w_next_q      = w_up_q;
    assign w_wrap        = w_up_c[DIGITS];
`endif

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_q     <= '0;
            r_carry <= 1'b0;
        end else if (bus.i_load) begin
            r_q     <= w_load_q;
            r_carry <= 1'b0;
        end else if (bus.i_enable) begin
            r_q     <= w_next_q;
            r_carry <= w_wrap;
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign bus.o_q     = r_q;
    assign bus.o_carry = r_carry;
    assign bus.o_tc    = w_wrap;
endmodule

// File: tb/tb_contador_bcd_param.sv
// Randomised bench for contador_bcd_param (DIGITS=2, MODULI=8'h6A) against an integer-count reference model.
module tb_contador_bcd_param;
    localparam int         DIGITS = 2;
    localparam logic [7:0] MODULI = 8'h6A;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    contador_bcd_param_if #(.DIGITS(DIGITS)) bus ();

    contador_bcd_param #(.DIGITS(DIGITS), .MODULI(MODULI)) dut (
        .i_clk   (clk),
        .i_clear (clear),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cnt;          // reference count as a plain integer 0..total-1
    bit exp_carry;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mod_of(input int i);
        logic [7:0] m;
        m = MODULI >> (4 * i);
        return int'(m[3:0]);
    endfunction

    function automatic int total();
        int t = 1;
        for (int i = 0; i < DIGITS; i++) t = t * mod_of(i);
        return t;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % mod_of(i));
            x = x / mod_of(i);
        end
        return r;
    endfunction

    function automatic int from_preset(input logic [7:0] p);
        int sum = 0;
        int w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(p[4*i +: 4]);
            if (d >= mod_of(i)) d = 0;
            sum = sum + d * w;
            w = w * mod_of(i);
        end
        return sum;
    endfunction

    task automatic step(input bit c, input bit l, input bit e, input bit d, input logic [7:0] p);
        bit eff_d;
        clear        = c;
        bus.i_load   = l;
        bus.i_enable = e;
        bus.i_down   = d;
        bus.i_preset = p;
`ifdef CONTADOR_BCD_DOWN_EN
        eff_d = d;
`else
        eff_d = 1'b0;
`endif
        #1;
        chk("tc", {31'd0, bus.o_tc}, eff_d ? {31'd0, cnt == 0} : {31'd0, cnt == total() - 1});
        @(posedge clk);
        #1;
        if (c) begin
            cnt = 0;
            exp_carry = 1'b0;
        end else if (l) begin
            cnt = from_preset(p);
            exp_carry = 1'b0;
        end else if (e) begin
            if (eff_d) begin
                exp_carry = (cnt == 0);
                cnt = (cnt + total() - 1) % total();
            end else begin
                exp_carry = (cnt == total() - 1);
                cnt = (cnt + 1) % total();
            end
        end else begin
            exp_carry = 1'b0;
        end
        chk("q", {24'd0, bus.o_q}, {24'd0, to_bcd(cnt)});
        chk("carry", {31'd0, bus.o_carry}, {31'd0, exp_carry});
    endtask

    initial begin
        clear        = 1'b1;
        bus.i_load   = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_down   = 1'b0;
        bus.i_preset = '0;
        @(posedge clk);
        #1;
        cnt = 0;
        exp_carry = 1'b0;
        chk("rst_q", {24'd0, bus.o_q}, 32'd0);
        chk("rst_carry", {31'd0, bus.o_carry}, 32'd0);

        // Full 00..59..00 sweep
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (60) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("sweep_end_q", {24'd0, bus.o_q}, 32'h00);
        chk("sweep_end_carry", {31'd0, bus.o_carry}, 32'd1);

        // Load beats enable, then counting resumes from the loaded value
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h47);
        chk("load47", {24'd0, bus.o_q}, 32'h47);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("after47", {24'd0, bus.o_q}, 32'h48);

        // Out-of-range nibbles load as zero
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h7C);
        chk("load7C", {24'd0, bus.o_q}, 32'h00);

        // Down request from 00 (wraps to 59 only when down counting is built in)
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        // Clear suppresses the wrap from 59
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h59);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("clr_wrap_q", {24'd0, bus.o_q}, 32'h00);

        // Hold at 59 with enable low
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h59);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("hold59", {24'd0, bus.o_q}, 32'h59);

        // Random mix of clear/load/enable/direction
        repeat (3000) begin
            step(($urandom % 32) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                 1'($urandom % 2), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
